// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO for the MIPS execute stage.
// Define MDU_MADD_EN to implement MADD/MADDU/MSUB/MSUBU (ops 6-9); otherwise they are no-ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] cnt, a_q, b_q, da, db, q_mag, r_mag, q, r;
  logic [3:0] op_q;
  logic [63:0] prod_s, prod_u, res;
  logic long_op, is_div, launch, done, wr, sgn;
`ifdef MDU_MADD_EN
  assign long_op = op <= 4'd3 || (op >= 4'd6 && op <= 4'd9);
`else
  assign long_op = op <= 4'd3;
`endif
  assign is_div = op[3:1] == 3'b001;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start && long_op ? RUN : IDLE) : (cnt == 32'd1 ? IDLE : RUN);
  always_comb begin
    busy = state == RUN;
    launch = state == IDLE && start && long_op;
    done = state == RUN && cnt == 32'd1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      HI <= '0;
      LO <= '0;
    end else if (launch) begin
      a_q <= A;
      b_q <= B;
      op_q <= op;
      cnt <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
    end else if (state == IDLE && start && op == 4'd4) HI <= A;
    else if (state == IDLE && start && op == 4'd5) LO <= A;
    else if (busy) begin
      cnt <= cnt - 32'd1;
      if (done && wr) {HI, LO} <= res;
    end
  // signed divide works on magnitudes so 0x80000000 / -1 naturally yields LO=0x80000000, HI=0
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    sgn = op_q == 4'd2;
    da = sgn && a_q[31] ? -a_q : a_q;
    db = sgn && b_q[31] ? -b_q : b_q;
    q_mag = da / db;
    r_mag = da % db;
    q = sgn && (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
    r = sgn && a_q[31] ? -r_mag : r_mag;
    wr = 1'b1;
    res = {HI, LO};
    case (op_q)
      4'd0: res = prod_s;
      4'd1: res = prod_u;
      4'd2, 4'd3: begin
        res = {r, q};
        wr = |b_q;
      end
`ifdef MDU_MADD_EN
      4'd6: res = {HI, LO} + prod_s;
      4'd7: res = {HI, LO} + prod_u;
      4'd8: res = {HI, LO} - prod_s;
      4'd9: res = {HI, LO} - prod_u;
`endif
      default: wr = 1'b0;
    endcase
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage MIPS pipeline, instantiated inside the execute stage. It accepts a one-cycle `start` from E with latched operands, runs a fixed-latency multi-cycle operation, and holds the 32-bit HI/LO registers read by MFHI/MFLO. `busy` and `start` feed the stall unit: a D-stage MD instruction stalls while either is high.

## Interface
- `MULT_CYCLES`, 5: busy cycles for multiply-class ops, ≥1
- `DIV_CYCLES`, 10: busy cycles for divide-class ops, ≥1
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- `start`  in  1  launch op in `op` with operands `A`,`B` this cycle
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10–15 no-op
- `A`  in  32  rs operand (forwarded value)
- `B`  in  32  rt operand (forwarded value)
- `busy`  out  1  operation in flight
- `HI`  out  32  HI register
- `LO`  out  32  LO register

## Operation
- States: IDLE, RUN. Reset: state IDLE, counter 0, `busy`=0, `HI`=0, `LO`=0, latched operands/op cleared.
- IDLE + `start` + op 0–3 or 6–9: latch `A`,`B`,`op`; load counter with MULT_CYCLES (ops 0,1,6–9) or DIV_CYCLES (ops 2,3); go RUN.
- IDLE + `start` + op 4/5: write `A` to HI/LO at that edge; stay IDLE; `busy` stays 0.
- IDLE + `start` + op 10–15: no effect.
- RUN: counter decrements each cycle; at the edge where it reaches 0, write result to {HI,LO} and return to IDLE.
- `start` while RUN: ignored entirely (stall unit guarantees it never happens; must not corrupt the in-flight op).
- MULT: {HI,LO} = signed 32×32 → 64. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend. DIVU: unsigned. Overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0): HI and LO unchanged; full DIV_CYCLES busy time still spent.
- MADD/MADDU: {HI,LO} += signed/unsigned A×B, modulo 2^64. MSUB/MSUBU: {HI,LO} −= product. Accumulate uses HI/LO value at completion edge.
- Result arithmetic may be combinational on latched operands; only the final write is timed.

## Timing
- `start` sampled at edge T (op 0–3, 6–9) → `busy`=1 from T through T+N, 0 after edge T+N; HI/LO new values visible after T+N. N = MULT_CYCLES or DIV_CYCLES.
- MTHI/MTLO: HI/LO updated after edge T; no busy.
- Back-to-back: new `start` accepted in the cycle `busy` first reads 0.
- `busy` is registered; no combinational path from `start` to `busy` (stall unit ORs `start` itself).
- `reset` asserted mid-RUN: immediately (asynchronously) IDLE, `busy`=0, HI=LO=0; op discarded.
- HI/LO outputs registered; reads during RUN return pre-op values.

## Configuration
- `MDU_MADD_EN` defined: ops 6–9 implemented as above.
- Not defined: ops 6–9 treated as no-ops (no busy, HI/LO untouched); accumulate adder/subtractor omitted from synthesis.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV B=0 → HI/LO unchanged after 10 cycles.
- MTHI A=0x12345678, next cycle MTLO A=0x9ABCDEF0 → HI/LO take values one edge after each, `busy` never rises; `start` with MULT during RUN of a DIV → ignored, DIV result intact.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADDU A=1,B=1 → HI=1, LO=0; MSUB A=1,B=1 → HI=0, LO=0xFFFFFFFF. Without macro: same stimulus → HI/LO unchanged, `busy`=0.
- Assert `reset` low 3 cycles into a DIV → `busy`=0, HI=LO=0 immediately; after release, new MULT completes normally.
